dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 144 ++++++++++++++
 tb/tb_dmem_responder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Big-endian byte-addressable data memory behind a valid/ready request/response pair.
// Latency: resp_valid 2 cycles after the request handshake; one request in flight.
// Backpressure: req_ready only in IDLE; the response holds until resp_ready. Macro DMEM_ALIGN_CHECK_EN errors misaligned accesses.
module dmem_responder #(
    parameter int SIZE = 16384
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        memwrite,
    input  logic [1:0]  dsize,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] rData,
    output logic        err
);
    localparam int AW    = $clog2(SIZE);
    localparam int WORDS = SIZE / 4;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_addr;
    logic [31:0]   r_wdata;
    logic          r_we;
    logic [1:0]    r_dsize;
    logic [31:0]   r_rdata;
    logic          r_err;
    logic [31:0]   r_mem [WORDS];

    logic          w_hs;
    logic          w_wen;
    logic          w_err;
    logic [1:0]    w_off;
    logic [AW-3:0] w_idx;
    logic [31:0]   w_word;
    logic [31:0]   w_rd;
    logic [31:0]   w_lane;
    logic [31:0]   w_wr_word;
    logic [3:0]    w_be;
    logic          w_unused_addr;

    assign w_hs          = req_valid & req_ready;
    assign w_idx         = r_addr[AW-1:2];
    assign w_word        = r_mem[w_idx];
    assign w_unused_addr = ^addr[31:AW];

    always_ff @(posedge clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (req_valid)  w_next = ACCESS;
            ACCESS:                  w_next = RESP;
            RESP:    if (resp_ready) w_next = IDLE;
            default:                 w_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (r_state == IDLE);
        resp_valid = (r_state == RESP);
        rData      = r_rdata;
        err        = r_err;
    end

    // Byte offset within the word after forcing the ignored low bits to zero.
    always_comb begin
        w_off = r_addr[1:0];
        w_err = 1'b0;
        case (r_dsize)
            2'b01:   w_off = {r_addr[1], 1'b0};
            2'b11:   w_off = 2'b00;
            2'b10:   w_err = 1'b1;
            default: w_off = r_addr[1:0];
        endcase
`ifdef DMEM_ALIGN_CHECK_EN
        if ((r_dsize == 2'b01 && r_addr[0]) || (r_dsize == 2'b11 && r_addr[1:0] != 2'b00))
            w_err = 1'b1;
`endif
    end

    // Offset 0 is the most significant byte; w_be[3] covers bits [31:24].
    always_comb begin
        w_rd   = '0;
        w_be   = '0;
        w_lane = '0;
        case (r_dsize)
            2'b00: begin
                w_rd   = {24'b0, 8'(w_word >> {~w_off, 3'b000})};
                w_be   = 4'b1000 >> w_off;
                w_lane = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_rd   = {16'b0, (w_off[1] ? w_word[15:0] : w_word[31:16])};
                w_be   = w_off[1] ? 4'b0011 : 4'b1100;
                w_lane = {2{r_wdata[15:0]}};
            end
            2'b11: begin
                w_rd   = w_word;
                w_be   = 4'b1111;
                w_lane = r_wdata;
            end
            default: w_rd = '0;
        endcase
    end

    always_comb begin
        w_wr_word = w_word;
        for (int i = 0; i < 4; i++)
            if (w_be[i]) w_wr_word[8*i +: 8] = w_lane[8*i +: 8];
    end

    assign w_wen = (r_state == ACCESS) & r_we & ~w_err & ~reset;

    always_ff @(posedge clock) begin
        if (w_wen) r_mem[w_idx] <= w_wr_word;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_hs) begin
                r_addr  <= addr[AW-1:0];
                r_wdata <= wdata;
                r_we    <= memwrite;
                r_dsize <= dsize;
            end
            if (r_state == ACCESS) begin
                r_rdata <= (r_we | w_err) ? 32'b0 : w_rd;
                r_err   <= w_err;
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder against a byte-array big-endian memory model.
module tb_dmem_responder;
    localparam int SIZE = 16384;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        memwrite = 1'b0;
    logic [1:0]  dsize = 2'b11;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] rData;
    logic        err;

    dmem_responder #(.SIZE(SIZE)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .addr(addr), .wdata(wdata), .memwrite(memwrite), .dsize(dsize),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .rData(rData), .err(err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] rd;
        logic        e;
        int          hs;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  mdl [SIZE];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    bit          stall = 0;
    bit          bp_rand = 0;
    bit          mon_skip = 0;

    always @(posedge clock) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
    endtask

    // Byte-level reference: lowest address holds the most significant byte.
    task automatic model(input bit we, input logic [1:0] ds, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output logic e);
        int n;
        int base;
        n  = (ds == 2'b00) ? 1 : (ds == 2'b01) ? 2 : 4;
        e  = (ds == 2'b10);
`ifdef DMEM_ALIGN_CHECK_EN
        if (ds != 2'b10 && (a % n) != 0) e = 1'b1;
`endif
        base = int'(a % SIZE);
        base = base - (base % n);
        rd   = '0;
        if (!e) begin
            for (int i = 0; i < n; i++) begin
                if (we) mdl[base + i] = wd[8*(n-1-i) +: 8];
                else    rd = (rd << 8) | {24'b0, mdl[base + i]};
            end
        end
    endtask

    task automatic do_req(input bit we, input logic [1:0] ds, input logic [31:0] a,
                          input logic [31:0] wd, input bit track);
        logic [31:0] rd;
        logic        e;
        exp_t        x;
        int          t;
        req_valid = 1'b1; memwrite = we; dsize = ds; addr = a; wdata = wd;
        t = 0;
        @(negedge clock);
        while (!req_ready && t < 200) begin
            @(negedge clock);
            t++;
        end
        if (!req_ready) begin
            chk("req_accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        if (track) begin
            model(we, ds, a, wd, rd, e);
            x.rd = rd; x.e = e; x.hs = cyc;
            exp_q.push_back(x);
        end
        @(posedge clock);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(posedge clock);
            t++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 32'd0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        forever begin
            @(posedge clock);
            #2 resp_ready = stall ? 1'b0 : (bp_rand ? ($urandom_range(0, 2) != 0) : 1'b1);
        end
    end

    // Monitor: latency on first appearance, stability while stalled, data on handshake.
    bit          prev_vld = 0;
    logic [31:0] held_rd;
    logic        held_e;
    always @(negedge clock) begin
        if (!mon_skip && resp_valid) begin
            if (!prev_vld) begin
                if (exp_q.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
                else chk("latency", 32'(cyc - exp_q[0].hs), 32'd2);
                held_rd = rData;
                held_e  = err;
            end else begin
                chk("stall_rdata", rData, held_rd);
                chk("stall_err", {31'b0, err}, {31'b0, held_e});
                chk("stall_req_ready", {31'b0, req_ready}, 32'd0);
            end
            if (resp_ready && exp_q.size() != 0) begin
                chk("rdata", rData, exp_q[0].rd);
                chk("err", {31'b0, err}, {31'b0, exp_q[0].e});
                void'(exp_q.pop_front());
            end
        end
        prev_vld = resp_valid && !resp_ready;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d responses outstanding", exp_q.size());
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic [1:0]  ds;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("reset_req_ready", {31'b0, req_ready}, 32'd1);
        chk("reset_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("reset_rdata", rData, 32'd0);
        chk("reset_err", {31'b0, err}, 32'd0);
        @(posedge clock);
        #1;

        for (int i = 0; i < 256; i++) do_req(1, 2'b11, 32'(i * 4), $urandom, 1);

        // Word round trip and byte lanes
        do_req(1, 2'b11, 32'h100, 32'hDEADBEEF, 1);
        do_req(0, 2'b11, 32'h100, 32'h0, 1);
        do_req(1, 2'b00, 32'h102, 32'h0000005A, 1);
        do_req(0, 2'b11, 32'h100, 32'h0, 1);
        do_req(0, 2'b00, 32'h103, 32'h0, 1);
        do_req(0, 2'b01, 32'h100, 32'h0, 1);
        do_req(0, 2'b01, 32'h102, 32'h0, 1);
        drain();

        // Backpressure with a competing request held valid
        do_req(0, 2'b11, 32'h100, 32'h0, 1);
        stall = 1;
        fork
            begin
                repeat (7) @(posedge clock);
                #1 stall = 0;
            end
            do_req(0, 2'b11, 32'(SIZE + 32'h100), 32'h0, 1);
        join
        drain();

        // Alignment and reserved size
        do_req(1, 2'b11, 32'h100, 32'hCAFEF00D, 1);
        do_req(1, 2'b01, 32'h101, 32'h00001234, 1);
        do_req(0, 2'b11, 32'h100, 32'h0, 1);
        do_req(1, 2'b11, 32'h102, 32'h89ABCDEF, 1);
        do_req(0, 2'b11, 32'h100, 32'h0, 1);
        do_req(1, 2'b10, 32'h100, 32'h55555555, 1);
        do_req(0, 2'b10, 32'h100, 32'h0, 1);
        do_req(0, 2'b11, 32'h100, 32'h0, 1);
        drain();

        // Reset during the ACCESS cycle of a store
        do_req(1, 2'b11, 32'h200, 32'h22222222, 1);
        drain();
        do_req(1, 2'b11, 32'h200, 32'h11111111, 0);
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_access_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_access_resp_valid", {31'b0, resp_valid}, 32'd0);
        @(posedge clock);
        #1;
        do_req(0, 2'b11, 32'h200, 32'h0, 1);
        drain();

        // Reset while a response is pending
        mon_skip = 1;
        stall = 1;
        @(posedge clock);
        #3;
        do_req(0, 2'b11, 32'h200, 32'h0, 0);
        @(posedge clock);
        @(negedge clock);
        chk("rst_resp_pending", {31'b0, resp_valid}, 32'd1);
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        stall = 0;
        @(negedge clock);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_resp_rdata", rData, 32'd0);
        chk("rst_resp_err", {31'b0, err}, 32'd0);
        @(posedge clock);
        #1 mon_skip = 0;

        // Random mix over the initialised window, with aliases above SIZE
        bp_rand = 1;
        for (int i = 0; i < 150; i++) begin
            a  = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) == 0) a = a + 32'(SIZE * $urandom_range(1, 3));
            ds = 2'($urandom_range(0, 3));
            do_req($urandom_range(0, 1) == 1, ds, a, $urandom, 1);
        end
        bp_rand = 0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
